// File: rtl/chunk_adder.sv
// chunk_adder: sequential adder/subtractor that handles a WIDTH-bit operand pair
// CHUNK bits per clock, keeping the inter-chunk carry in a register.
// Optional feature macro: CHUNK_ADDER_OVF_EN enables the signed overflow flag.
// When the macro is undefined, ovf is held at 0.
module chunk_adder #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic [CHUNK:0]   cc;

  // Select the active chunk and ripple it through CHUNK full-adder cells.
  always_comb begin
    base  = BW'(idx_q) * BW'(CHUNK);
    a_ch  = a_q[base +: CHUNK];
    b_ch  = b_q[base +: CHUNK];
    s_ch  = '0;
    cc    = '0;
    cc[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      s_ch[i]  = a_ch[i] ^ b_ch[i] ^ cc[i];
      cc[i+1]  = (a_ch[i] & b_ch[i]) | (cc[i] & (a_ch[i] ^ b_ch[i]));
    end
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is a + ~b + ~borrow, so inversion happens once at capture.
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          carry_d = sub ? ~cin : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        out_d[base +: CHUNK] = s_ch;
        carry_d              = cc[CHUNK];
        if (idx_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = cc[CHUNK];
          zero_d  = (out_d == '0);
`ifdef CHUNK_ADDER_OVF_EN
          // Top chunk holds the MSB: compare carry into it with carry out of it.
          ovf_d   = cc[CHUNK] ^ cc[CHUNK-1];
`else
          ovf_d   = 1'b0;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Testbench for chunk_adder: directed and randomized operations checked against
// a plain-arithmetic reference model. Honours CHUNK_ADDER_OVF_EN for ovf.
module tb_chunk_adder;

  localparam int unsigned W = 40;
  localparam int unsigned C = 8;
  localparam int unsigned N = W / C;
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));
`ifdef CHUNK_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         cout;
  logic         zero;
  logic         ovf;

  int total;
  int bad;

  chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .cin  (cin),
    .in1  (in1),
    .in2  (in2),
    .busy (busy),
    .done (done),
    .out  (out),
    .cout (cout),
    .zero (zero),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: modular result, unsigned no-borrow/carry, signed range check.
  function automatic void model(input logic s, input logic ci, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] o,
                                output logic co, output logic z, output logic v);
    logic [W:0] t;
    longint sx, sy, sr;
    if (!s) begin
      t  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      o  = t[W-1:0];
      co = t[W];
    end else begin
      o  = x - y - W'(ci);
      co = ({1'b0, x} >= ({1'b0, y} + (W+1)'(ci)));
    end
    z  = (o == '0);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = s ? (sx - sy - longint'(ci)) : (sx + sy + longint'(ci));
    v  = OVF_ON & ((sr > MAXS) || (sr < MINS));
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = '1;
      2:       r = {1'b0, {(W-1){1'b1}}};
      3:       r = {1'b1, {(W-1){1'b0}}};
      default: r = W'({$urandom(), $urandom()});
    endcase
    return r;
  endfunction

  // Drive one operation, scramble inputs while busy, and collect the result.
  task automatic run_op(input logic s, input logic ci, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [W-1:0] o, output logic co,
                        output logic z, output logic v, output int lat, output logic dn_after);
    @(negedge clk);
    start = 1'b1; sub = s; cin = ci; in1 = x; in2 = y;
    @(negedge clk);
    start = 1'b0; sub = 1'($urandom()); cin = 1'($urandom());
    in1 = W'({$urandom(), $urandom()}); in2 = W'({$urandom(), $urandom()});
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    o = out; co = cout; z = zero; v = ovf;
    @(negedge clk);
    dn_after = done;
  endtask

  task automatic test_reset();
    logic [W-1:0] o;
    logic co, z, v, dn, seen;
    int lat;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", zero); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    run_op(1'b0, 1'b0, W'(40'h12), W'(40'h34), o, co, z, v, lat, dn);
    total++; if (o !== W'(40'h46)) begin bad++; $display("FAIL pre_reset_out: got %h want %h", o, W'(40'h46)); end
    // Reset on the edge after E0 discards the operation.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; cin = 1'b0; in1 = W'(40'h1); in2 = W'(40'h1);
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (out !== '0) begin bad++; $display("FAIL midrst_out: got %h want 0", out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_done: got %b want 0", seen); end
    // Reset wins over start on the same edge.
    rst = 1'b1; start = 1'b1; in1 = W'(40'h5); in2 = W'(40'h3);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_prio_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [W-1:0] dx [7] = '{40'h00_FFFF_FFFF, 40'hFF_FFFF_FFFF, 40'h5, 40'h5, 40'h9,
                             40'h7F_FFFF_FFFF, 40'hFF};
    logic [W-1:0] dy [7] = '{40'h1, 40'h1, 40'h7, 40'h7, 40'h9, 40'h1, 40'h0};
    logic [W-1:0] dq [7] = '{40'h01_0000_0000, 40'h0, 40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFD,
                             40'h0, 40'h80_0000_0000, 40'h100};
    logic ds [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic dc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic dco [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic dz [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] o;
    logic co, z, v, dn, ev;
    int lat;
    for (int k = 0; k < 7; k++) begin
      ev = (k == 5) ? OVF_ON : 1'b0;
      run_op(ds[k], dc[k], dx[k], dy[k], o, co, z, v, lat, dn);
      total++; if (lat !== N) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, N); end
      total++; if (o !== dq[k]) begin bad++; $display("FAIL dir%0d_out: got %h want %h", k, o, dq[k]); end
      total++; if (co !== dco[k]) begin bad++; $display("FAIL dir%0d_cout: got %b want %b", k, co, dco[k]); end
      total++; if (z !== dz[k]) begin bad++; $display("FAIL dir%0d_zero: got %b want %b", k, z, dz[k]); end
      total++; if (v !== ev) begin bad++; $display("FAIL dir%0d_ovf: got %b want %b", k, v, ev); end
      total++; if (dn !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width: got %b want 0", k, dn); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, o, eo;
    logic s, ci, co, z, v, dn, eco, ez, ev;
    int lat;
    for (int k = 0; k < 40; k++) begin
      x = rand_word(); y = rand_word();
      s = 1'($urandom()); ci = 1'($urandom());
      model(s, ci, x, y, eo, eco, ez, ev);
      run_op(s, ci, x, y, o, co, z, v, lat, dn);
      total++; if (lat !== N) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, N); end
      total++; if (o !== eo) begin bad++; $display("FAIL rnd%0d_out: got %h want %h", k, o, eo); end
      total++; if (co !== eco) begin bad++; $display("FAIL rnd%0d_cout: got %b want %b", k, co, eco); end
      total++; if (z !== ez) begin bad++; $display("FAIL rnd%0d_zero: got %b want %b", k, z, ez); end
      total++; if (v !== ev) begin bad++; $display("FAIL rnd%0d_ovf: got %b want %b", k, v, ev); end
      total++; if (dn !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_width: got %b want 0", k, dn); end
    end
  endtask

  // start held high while busy must not disturb or restart the operation.
  task automatic test_handshake();
    logic [W-1:0] x, y, eo;
    logic eco, ez, ev;
    int lat;
    x = W'(40'h12_3456_789A); y = W'(40'h0F_0F0F_0F0F);
    model(1'b1, 1'b1, x, y, eo, eco, ez, ev);
    @(negedge clk);
    start = 1'b1; sub = 1'b1; cin = 1'b1; in1 = x; in2 = y;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      start = (lat < N - 1) ? 1'b1 : 1'b0;
      sub = 1'($urandom()); cin = 1'($urandom());
      in1 = W'({$urandom(), $urandom()}); in2 = W'({$urandom(), $urandom()});
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    total++; if (lat !== N) begin bad++; $display("FAIL hs_latency: got %0d want %0d", lat, N); end
    total++; if (out !== eo) begin bad++; $display("FAIL hs_out: got %h want %h", out, eo); end
    total++; if (cout !== eco) begin bad++; $display("FAIL hs_cout: got %b want %b", cout, eco); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_no_restart: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL hs_done_clear: got %b want 0", done); end
  endtask

  // A start in the done cycle is accepted; results arrive N+1 cycles apart.
  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, x2, y2, e1, e2;
    logic c1, z1, v1, c2, z2, v2;
    int lat, gap;
    x1 = W'(40'hAA_5555_00FF); y1 = W'(40'h55_AAAA_FF01);
    x2 = W'(40'h00_0000_0010); y2 = W'(40'h00_0000_0020);
    model(1'b0, 1'b0, x1, y1, e1, c1, z1, v1);
    model(1'b1, 1'b0, x2, y2, e2, c2, z2, v2);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; cin = 1'b0; in1 = x1; in2 = y1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (out !== e1) begin bad++; $display("FAIL b2b_first_out: got %h want %h", out, e1); end
    total++; if (cout !== c1) begin bad++; $display("FAIL b2b_first_cout: got %b want %b", cout, c1); end
    start = 1'b1; sub = 1'b1; cin = 1'b0; in1 = x2; in2 = y2;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    total++; if (gap !== N + 1) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", gap, N + 1); end
    total++; if (out !== e2) begin bad++; $display("FAIL b2b_second_out: got %h want %h", out, e2); end
    total++; if (cout !== c2) begin bad++; $display("FAIL b2b_second_cout: got %b want %b", cout, c2); end
    repeat (3) @(negedge clk);
    total++; if (out !== e2) begin bad++; $display("FAIL b2b_hold_out: got %h want %h", out, e2); end
    total++; if (zero !== z2) begin bad++; $display("FAIL b2b_hold_zero: got %b want %b", zero, z2); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunk_adder.md
# chunk_adder

Sequential, parametrised adder/subtractor for the arithmetic unit. It processes a WIDTH-bit operand pair CHUNK bits per clock and carries between chunks in a register, so full 40-bit IAS words are handled by a narrow carry chain. A start/busy/done handshake lets the controller sequence it alongside other multi-cycle units. It supersedes the fixed 8-bit combinational ripple adder: width is configurable, and it adds subtract mode, carry-in and flag outputs.

## Interface
- WIDTH, 40: operand and result width. Must be an integer multiple of CHUNK.
- CHUNK, 8: bits added per cycle. Must be at least 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = in1 + in2 + cin; 1 = in1 − in2 − cin (cin acts as borrow-in).
- cin  input  1  carry-in for add, borrow-in for subtract.
- in1, in2  input  WIDTH  operands; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a completed result.
- out  output  WIDTH  result.
- cout  output  1  final carry out. For subtract, 1 = no borrow.
- zero  output  1  out == 0.
- ovf  output  1  signed two's-complement overflow (see Configuration).

## Operation
- N = WIDTH/CHUNK. States: IDLE, RUN.
- IDLE with start=1:
  - Latch a = in1.
  - Latch b = sub ? ~in2 : in2.
  - Set carry = sub ? ~cin : cin.
  - Set idx = 0, busy = 1, go to RUN.
- RUN, every edge:
  - {c, s} = a[idx chunk] + b[idx chunk] + carry, computed as a CHUNK-bit ripple of full-adder cells.
  - Write s into out[idx*CHUNK +: CHUNK] and set carry = c.
  - If idx < N−1: increment idx.
- On the RUN edge where idx == N−1:
  - Go to IDLE; set busy = 0 and done = 1.
  - Set cout = c.
  - Set zero from the complete result.
  - Set ovf = carry into MSB XOR carry out of MSB.
- done clears to 0 on the next edge unless a new operation completes on that edge.
- start while busy is ignored; there is no queueing.
- Operands are captured at start, so in1/in2/sub/cin may change freely while busy.
- out, cout, zero and ovf hold their values in IDLE until the next completion.
- out is updated chunk by chunk during RUN and is valid only when done=1 or in IDLE after a completion.
- rst (in any state, including mid-RUN):
  - State goes to IDLE.
  - idx, carry, out, cout, zero, ovf, busy and done all go to 0.
  - A partial result is discarded.

## Timing
- Reset values: busy=0, done=0, out=0, cout=0, zero=0, ovf=0.
- Accepting edge E0 is the edge where start=1 is sampled in IDLE.
  - busy is high from E0 to E_N.
  - done is high for exactly one cycle, following edge E_N.
  - Latency is N cycles; for defaults N=5.
- Back-to-back operation:
  - start=1 during the done cycle is accepted (state is IDLE).
  - That gives one result every N+1 cycles at most.
- Degenerate CHUNK == WIDTH: N=1, single-cycle RUN.
- Arithmetic is modulo 2^WIDTH; the carry out of the top chunk appears only on cout.
- rst has priority over start on the same edge.

## Configuration
- Macro: CHUNK_ADDER_OVF_EN.
- Defined:
  - ovf is computed as above.
  - The carry into the MSB is tapped from the top chunk's ripple chain.
- Undefined:
  - ovf is tied to 0.
  - No MSB-carry logic is synthesised.
  - The port remains present so instantiations do not change.

## Test plan
- Reset mid-operation: start add with in1=40'h1, in2=40'h1; assert rst on the edge after E0 → next cycle busy=0, out=0, done=0; no done pulse follows.
- Add across all chunks: in1=40'h00_FFFF_FFFF, in2=40'h1, cin=0 → done exactly 5 cycles after E0, out=40'h01_0000_0000, cout=0, zero=0.
- Add with full wrap: in1=40'hFF_FFFF_FFFF, in2=40'h1 → out=0, cout=1, zero=1.
- Subtract with borrow: sub=1, in1=40'h5, in2=40'h7, cin=0 → out=40'hFF_FFFF_FFFE, cout=0. Repeat with cin=1 → out=40'hFF_FFFF_FFFD.
- Overflow (macro defined): in1=40'h7F_FFFF_FFFF, in2=40'h1 → ovf=1, out=40'h80_0000_0000. With the macro undefined → ovf=0.
- Handshake:
  - start held high while busy → ignored; operands are taken only at E0.
  - start during the done cycle → second operation accepted; second done arrives 6 cycles after the first.
